ss_bus_seq: RTL and testbench

// - Initiator side of the mapper save-state bus: drives ss_act/ss_we/ss_addr/write data and
//   an m2 strobe into a mapper, reads ss_rdat back.
// - SAVE walks addresses 0..SS_LEN-1 and streams each ss_rdat byte out.
// - RESTORE takes a byte stream and writes each byte to the mapper on an m2 falling edge.
// - Sits between the save-state DMA/buffer and the active mapper's ss_ctrl inputs.

---
 rtl/ss_bus_seq.sv | 143 ++++++++++++++
 tb/tb_ss_bus_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ss_bus_seq.sv
// ss_bus_seq: save-state bus initiator; SAVE streams mapper slots out, RESTORE writes a byte stream in.
// Optional readback verify of each restored slot is built when SS_VERIFY_EN is defined.
module ss_bus_seq #(
  parameter int SS_LEN = 256,
  parameter int M2_HI  = 3,
  parameter int M2_LO  = 3,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  output logic       busy,
  output logic       done,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  output logic       ss_m2,
  input  logic [7:0] ss_rdat,
  output logic [7:0] out_dat,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_dat,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       vfy_err
);
  typedef enum logic [3:0] {IDLE, SETUP, SAMPLE, PUSH, FETCH, M2H, M2L, VCHK, NEXT, DONE} state_t;
  state_t      st_q;
  logic        op_q, busy_q, done_q, act_q, we_q, m2_q, oval_q, irdy_q;
  logic [8:0]  slot_q;
  logic [15:0] cnt_q;
  logic [7:0]  addr_q, wdat_q, odat_q;
`ifdef SS_VERIFY_EN
  logic        verr_q;
  assign vfy_err = verr_q;
`else
  assign vfy_err = 1'b0;
`endif
  assign busy      = busy_q;
  assign done      = done_q;
  assign ss_act    = act_q;
  assign ss_we     = we_q;
  assign ss_addr   = addr_q;
  assign ss_wdat   = wdat_q;
  assign ss_m2     = m2_q;
  assign out_dat   = odat_q;
  assign out_valid = oval_q;
  assign in_ready  = irdy_q;
  // Outputs are registered alongside the state, so each is set on the transition into its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      op_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      act_q  <= 1'b0;
      we_q   <= 1'b0;
      m2_q   <= 1'b0;
      oval_q <= 1'b0;
      irdy_q <= 1'b0;
      slot_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      odat_q <= '0;
`ifdef SS_VERIFY_EN
      verr_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (start) begin
          st_q   <= SETUP;
          op_q   <= op;
          slot_q <= '0;
          cnt_q  <= '0;
          addr_q <= '0;
          act_q  <= 1'b1;
          busy_q <= 1'b1;
`ifdef SS_VERIFY_EN
          verr_q <= 1'b0;
`endif
        end
        SETUP: if (cnt_q == 16'(SETTLE - 1)) begin
          cnt_q  <= '0;
          st_q   <= op_q ? FETCH : SAMPLE;
          irdy_q <= op_q;
        end else cnt_q <= cnt_q + 16'd1;
        SAMPLE: begin
          odat_q <= ss_rdat;
          oval_q <= 1'b1;
          st_q   <= PUSH;
        end
        PUSH: if (out_ready) begin
          oval_q <= 1'b0;
          st_q   <= NEXT;
        end
        FETCH: if (in_valid) begin
          wdat_q <= in_dat;
          irdy_q <= 1'b0;
          we_q   <= 1'b1;
          m2_q   <= 1'b1;
          st_q   <= M2H;
        end
        M2H: if (cnt_q == 16'(M2_HI - 1)) begin
          cnt_q <= '0;
          m2_q  <= 1'b0;
          st_q  <= M2L;
        end else cnt_q <= cnt_q + 16'd1;
        M2L: if (cnt_q == 16'(M2_LO - 1)) begin
          cnt_q <= '0;
          we_q  <= 1'b0;
`ifdef SS_VERIFY_EN
          st_q  <= VCHK;
`else
          st_q  <= NEXT;
`endif
        end else cnt_q <= cnt_q + 16'd1;
`ifdef SS_VERIFY_EN
        VCHK: if (cnt_q == 16'(SETTLE - 1)) begin
          cnt_q <= '0;
          if (ss_rdat != wdat_q) verr_q <= 1'b1;
          st_q  <= NEXT;
        end else cnt_q <= cnt_q + 16'd1;
`endif
        NEXT: if (slot_q == 9'(SS_LEN - 1)) begin
          act_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          st_q   <= DONE;
        end else begin
          slot_q <= slot_q + 9'd1;
          addr_q <= addr_q + 8'd1;
          st_q   <= SETUP;
        end
        DONE: st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ss_bus_seq.sv
// tb_ss_bus_seq: directed bench for ss_bus_seq with an 8-slot mapper model (a_*) and a 1-slot CNROM-style bank register (b_*).
module tb_ss_bus_seq;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic       a_start = 0, a_op = 0, a_ordy = 0, a_ivalid = 0;
  logic [7:0] a_idat = 0;
  logic       a_busy, a_done, a_act, a_we, a_m2, a_ovalid, a_iready, a_verr;
  logic [7:0] a_addr, a_wdat, a_odat, a_rdat;
  logic       b_start = 0, b_op = 0, b_ivalid = 0;
  logic [7:0] b_idat = 0;
  logic       b_busy, b_done, b_act, b_we, b_m2, b_ovalid, b_iready, b_verr;
  logic [7:0] b_addr, b_wdat, b_odat;
  logic [7:0] b_bank = 0;
  logic [7:0] mem [256];
  logic [255:0] wr = '0;
  logic drop = 0;
  logic [7:0] sv [256];
  int n_sv = 0, a_ndone = 0, a_nhi = 0, a_nfall = 0, b_ndone = 0, b_nhi = 0, b_nbad = 0;
  int n_chk = 0, n_fail = 0;
  wire [31:0] a_all = {a_busy, a_done, a_act, a_we, a_addr, a_wdat, a_m2, a_odat, a_ovalid, a_iready, a_verr};
  wire [31:0] b_all = {b_busy, b_done, b_act, b_we, b_addr, b_wdat, b_m2, b_odat, b_ovalid, b_iready, b_verr};
  assign a_rdat = wr[a_addr] ? mem[a_addr] : a_addr ^ 8'hA5;

  ss_bus_seq #(.SS_LEN(8), .M2_HI(3), .M2_LO(3), .SETTLE(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .op(a_op), .busy(a_busy), .done(a_done),
    .ss_act(a_act), .ss_we(a_we), .ss_addr(a_addr), .ss_wdat(a_wdat), .ss_m2(a_m2), .ss_rdat(a_rdat),
    .out_dat(a_odat), .out_valid(a_ovalid), .out_ready(a_ordy),
    .in_dat(a_idat), .in_valid(a_ivalid), .in_ready(a_iready), .vfy_err(a_verr));
  ss_bus_seq #(.SS_LEN(1), .M2_HI(3), .M2_LO(3), .SETTLE(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .op(b_op), .busy(b_busy), .done(b_done),
    .ss_act(b_act), .ss_we(b_we), .ss_addr(b_addr), .ss_wdat(b_wdat), .ss_m2(b_m2), .ss_rdat(b_bank),
    .out_dat(b_odat), .out_valid(b_ovalid), .out_ready(1'b1),
    .in_dat(b_idat), .in_valid(b_ivalid), .in_ready(b_iready), .vfy_err(b_verr));

  // Mapper models latch on the falling edge of m2; slot 1 can be made to lose bit 7.
  always @(negedge a_m2) begin
    a_nfall++;
    if (a_act && a_we) begin
      mem[a_addr] = (drop && a_addr == 8'd1) ? (a_wdat & 8'h7F) : a_wdat;
      wr[a_addr] = 1'b1;
    end
  end
  always @(negedge b_m2) if (b_we) b_bank = b_wdat;
  always @(negedge clk) begin
    if (a_ovalid && a_ordy) begin
      sv[n_sv] = a_odat;
      n_sv++;
    end
    if (a_done) a_ndone++;
    if (a_m2) a_nhi++;
    if (b_done) b_ndone++;
    if (b_m2) begin
      b_nhi++;
      if (!(b_we && b_act && b_addr == 8'd0)) b_nbad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic a_go(input logic o);
    step();
    a_op = o;
    a_start = 1;
    step();
    a_start = 0;
  endtask
  task automatic wait_a_done(input string tag);
    for (int k = 0; k < 3000 && !a_done; k++) @(negedge clk);
    chk(tag, a_done, 1);
    step();
  endtask

  initial begin
    int base, d0, h0, f0;
    logic stable;
    repeat (3) @(negedge clk);
    chk("rst_a", a_all, 0);
    chk("rst_b", b_all, 0);
    step();
    rst = 0;
    // plain SAVE
    a_ordy = 1;
    base = n_sv; d0 = a_ndone; h0 = a_nhi;
    a_go(0);
    wait_a_done("save_done");
    chk("save_cnt", n_sv - base, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("save_d%0d", i), sv[base + i], i ^ 8'hA5);
    chk("save_done1", a_ndone - d0, 1);
    chk("save_no_m2", a_nhi - h0, 0);
    chk("save_idle", {a_busy, a_act}, 0);
    // SAVE with a 10-cycle stall on slot 2
    base = n_sv;
    a_go(0);
    for (int k = 0; k < 200 && a_addr != 8'd2; k++) @(negedge clk);
    a_ordy = 0;
    for (int k = 0; k < 50 && !a_ovalid; k++) @(negedge clk);
    chk("stall_valid", a_ovalid, 1);
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(a_ovalid && a_odat == 8'hA7 && a_addr == 8'd2)) stable = 0;
    end
    chk("stall_hold", stable, 1);
    step();
    a_ordy = 1;
    wait_a_done("stall_done");
    chk("stall_cnt", n_sv - base, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stall_d%0d", i), sv[base + i], i ^ 8'hA5);
    // RESTORE with input gaps and an ignored start pulse
    base = n_sv; d0 = a_ndone; f0 = a_nfall;
    a_go(1);
    for (int i = 0; i < 8; i++) begin
      a_ivalid = 0;
      if (i == 3) begin
        a_op = 0;
        a_start = 1;
        step();
        a_start = 0;
      end
      repeat (16) step();
      chk($sformatf("rs_wait%0d", i), {a_iready, a_m2, a_addr}, {1'b1, 1'b0, 8'(i)});
      chk($sformatf("rs_fall%0d", i), a_nfall - f0, i);
      a_idat = 8'h10 + 8'(i);
      a_ivalid = 1;
      step();
    end
    a_ivalid = 0;
    wait_a_done("rs_done");
    chk("rs_fall8", a_nfall - f0, 8);
    chk("rs_done1", a_ndone - d0, 1);
    chk("rs_no_out", n_sv - base, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rs_mem%0d", i), mem[i], 8'h10 + i);
    // reset in the middle of slot 5's m2-high window
    a_idat = 8'h50;
    a_ivalid = 1;
    a_go(1);
    for (int k = 0; k < 2000 && !(a_m2 && a_addr == 8'd5); k++) @(negedge clk);
    chk("rst_at5", {a_m2, a_addr}, {1'b1, 8'd5});
    rst = 1;
    #1;
    chk("rst_mid", a_all, 0);
    a_ivalid = 0;
    step();
    step();
    rst = 0;
    base = n_sv;
    a_go(0);
    wait_a_done("post_done");
    chk("post_cnt", n_sv - base, 8);
    for (int i = 0; i < 8; i++)
      if (i != 5) chk($sformatf("post_d%0d", i), sv[base + i], i < 5 ? 8'h50 : 8'h10 + i);
    // single-slot restore into a bank register
    b_idat = 8'h03;
    b_ivalid = 1;
    step();
    b_op = 1;
    b_start = 1;
    step();
    b_start = 0;
    for (int k = 0; k < 200 && !b_done; k++) @(negedge clk);
    chk("b_done", b_done, 1);
    step();
    b_ivalid = 0;
    chk("b_m2_hi", b_nhi, 3);
    chk("b_m2_ctx", b_nbad, 0);
    chk("b_bank", b_bank, 8'h03);
    chk("b_done1", b_ndone, 1);
`ifdef SS_VERIFY_EN
    drop = 1;
    a_idat = 8'h80;
    a_ivalid = 1;
    a_go(1);
    wait_a_done("vfy_done");
    a_ivalid = 0;
    chk("vfy_set", a_verr, 1);
    repeat (3) step();
    chk("vfy_hold", a_verr, 1);
    drop = 0;
    a_go(0);
    chk("vfy_clr", a_verr, 0);
    wait_a_done("vfy_save");
`else
    chk("vfy_tied", a_verr, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
